// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, ALU function codes and the
// ID/MEX pipeline-register state encoding.
package cpu_pkg;

    localparam int unsigned DataWDefault = 16;
    localparam int unsigned RegWDefault  = 3;
    localparam int unsigned AluFuncW     = 4;

    localparam logic [AluFuncW-1:0] AluAdd  = 4'h0;
    localparam logic [AluFuncW-1:0] AluSub  = 4'h1;
    localparam logic [AluFuncW-1:0] AluAnd  = 4'h2;
    localparam logic [AluFuncW-1:0] AluOr   = 4'h3;
    localparam logic [AluFuncW-1:0] AluXor  = 4'h4;
    localparam logic [AluFuncW-1:0] AluSll  = 4'h5;
    localparam logic [AluFuncW-1:0] AluSrl  = 4'h6;
    localparam logic [AluFuncW-1:0] AluSra  = 4'h7;
    localparam logic [AluFuncW-1:0] AluSlt  = 4'h8;
    localparam logic [AluFuncW-1:0] AluPass = 4'h9;

    typedef enum logic {
        StRun  = 1'b0,
        StHold = 1'b1
    } mex_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_mex_stage_if.sv
// ID -> MEX pipeline-register bus: decoded fields and hazard controls in,
// registered id_mex_* fields and the IF/ID stall out.
interface id_mex_stage_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned REG_W  = RegWDefault
);

    logic                id_valid;
    logic [REG_W-1:0]    id_reg1;
    logic [REG_W-1:0]    id_reg2;
    logic [REG_W-1:0]    id_wrt_reg;
    logic [AluFuncW-1:0] id_alu_func;
    logic [DATA_W-1:0]   id_rd1_data;
    logic [DATA_W-1:0]   id_rd2_data;
    logic [DATA_W-1:0]   id_imm;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_reg_write;
    logic                mem_busy;
    logic                flush;

    logic                id_stall;
    logic                id_mex_valid;
    logic [REG_W-1:0]    id_mex_reg1;
    logic [REG_W-1:0]    id_mex_reg2;
    logic [REG_W-1:0]    id_mex_wrt_reg;
    logic [AluFuncW-1:0] id_mex_alu_func;
    logic [DATA_W-1:0]   id_mex_rd1;
    logic [DATA_W-1:0]   id_mex_rd2;
    logic [DATA_W-1:0]   id_mex_imm;
    logic                id_mex_mem_read;
    logic                id_mex_mem_write;
    logic                id_mex_reg_write;

    modport master (
        output id_valid, id_reg1, id_reg2, id_wrt_reg, id_alu_func,
               id_rd1_data, id_rd2_data, id_imm,
               id_mem_read, id_mem_write, id_reg_write, mem_busy, flush,
        input  id_stall, id_mex_valid, id_mex_reg1, id_mex_reg2, id_mex_wrt_reg,
               id_mex_alu_func, id_mex_rd1, id_mex_rd2, id_mex_imm,
               id_mex_mem_read, id_mex_mem_write, id_mex_reg_write
    );

    modport slave (
        input  id_valid, id_reg1, id_reg2, id_wrt_reg, id_alu_func,
               id_rd1_data, id_rd2_data, id_imm,
               id_mem_read, id_mem_write, id_reg_write, mem_busy, flush,
        output id_stall, id_mex_valid, id_mex_reg1, id_mex_reg2, id_mex_wrt_reg,
               id_mex_alu_func, id_mex_rd1, id_mex_rd2, id_mex_imm,
               id_mex_mem_read, id_mex_mem_write, id_mex_reg_write
    );

endinterface

// File: rtl/id_mex_stage_hazard_detect.sv
// Load-use detector: a load sitting in MEX whose destination matches either
// source register of the instruction currently in ID.
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int unsigned REG_W = RegWDefault
) (
    input  logic             mex_valid_i,
    input  logic             mex_mem_read_i,
    input  logic [REG_W-1:0] mex_wrt_reg_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_reg1_i,
    input  logic [REG_W-1:0] id_reg2_i,
    output logic             load_use_o
);

    logic reg_match;

    // reg2 is compared even for immediate forms; an occasional extra bubble is harmless.
    assign reg_match  = (mex_wrt_reg_i == id_reg1_i) | (mex_wrt_reg_i == id_reg2_i);
    assign load_use_o = mex_valid_i & mex_mem_read_i & id_valid_i & reg_match;

endmodule

// File: rtl/id_mex_stage.sv
// ID/MEX pipeline register with load-use bubbles, memory-wait hold and branch flush.
// Define ID_MEX_PERF_CNT_EN to add the bubble_cnt/hold_cnt performance counters.
module id_mex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned REG_W  = RegWDefault
) (
    input  logic          clk,
    input  logic          rst,
    id_mex_stage_if.slave bus
`ifdef ID_MEX_PERF_CNT_EN
    ,
    output logic [15:0]   bubble_cnt,
    output logic [15:0]   hold_cnt
`endif
);

    typedef struct packed {
        logic                valid;
        logic [REG_W-1:0]    reg1;
        logic [REG_W-1:0]    reg2;
        logic [REG_W-1:0]    wrt_reg;
        logic [AluFuncW-1:0] alu_func;
        logic [DATA_W-1:0]   rd1;
        logic [DATA_W-1:0]   rd2;
        logic [DATA_W-1:0]   imm;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
    } id_mex_t;

    mex_state_e state_q, state_d;
    logic       flush_pending_q, flush_pending_d;
    id_mex_t    pipe_q, pipe_d;
    id_mex_t    id_capture;
    logic       load_use;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .mex_valid_i    (pipe_q.valid),
        .mex_mem_read_i (pipe_q.mem_read),
        .mex_wrt_reg_i  (pipe_q.wrt_reg),
        .id_valid_i     (bus.id_valid),
        .id_reg1_i      (bus.id_reg1),
        .id_reg2_i      (bus.id_reg2),
        .load_use_o     (load_use)
    );

    // Invalid instructions flow through but can never write or touch memory.
    always_comb begin
        id_capture           = '0;
        id_capture.valid     = bus.id_valid;
        id_capture.reg1      = bus.id_reg1;
        id_capture.reg2      = bus.id_reg2;
        id_capture.wrt_reg   = bus.id_wrt_reg;
        id_capture.alu_func  = bus.id_alu_func;
        id_capture.rd1       = bus.id_rd1_data;
        id_capture.rd2       = bus.id_rd2_data;
        id_capture.imm       = bus.id_imm;
        id_capture.mem_read  = bus.id_mem_read & bus.id_valid;
        id_capture.mem_write = bus.id_mem_write & bus.id_valid;
        id_capture.reg_write = bus.id_reg_write & bus.id_valid;
    end

    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        pipe_d          = pipe_q;
        if (bus.mem_busy) begin
            // MEX is frozen; a flush seen now is applied once it unfreezes.
            state_d = StHold;
            if (bus.flush) begin
                flush_pending_d = 1'b1;
            end
        end else begin
            state_d         = StRun;
            flush_pending_d = 1'b0;
            if (bus.flush || flush_pending_q || load_use) begin
                pipe_d = '0;
            end else begin
                pipe_d = id_capture;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StRun;
            flush_pending_q <= 1'b0;
            pipe_q          <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            pipe_q          <= pipe_d;
        end
    end

    assign bus.id_stall = ~rst & ((state_q == StHold) | bus.mem_busy | load_use);

    assign bus.id_mex_valid     = pipe_q.valid;
    assign bus.id_mex_reg1      = pipe_q.reg1;
    assign bus.id_mex_reg2      = pipe_q.reg2;
    assign bus.id_mex_wrt_reg   = pipe_q.wrt_reg;
    assign bus.id_mex_alu_func  = pipe_q.alu_func;
    assign bus.id_mex_rd1       = pipe_q.rd1;
    assign bus.id_mex_rd2       = pipe_q.rd2;
    assign bus.id_mex_imm       = pipe_q.imm;
    assign bus.id_mex_mem_read  = pipe_q.mem_read;
    assign bus.id_mex_mem_write = pipe_q.mem_write;
    assign bus.id_mex_reg_write = pipe_q.reg_write;

`ifdef ID_MEX_PERF_CNT_EN
    logic        load_use_bubble;
    logic [15:0] bubble_cnt_q;
    logic [15:0] hold_cnt_q;

    // Only bubbles caused by the hazard itself; a flush bubble that hides one is not counted.
    assign load_use_bubble = load_use & ~bus.mem_busy & ~bus.flush & ~flush_pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            if (load_use_bubble) begin
                bubble_cnt_q <= sat_inc16(bubble_cnt_q);
            end
            if (bus.mem_busy) begin
                hold_cnt_q <= sat_inc16(hold_cnt_q);
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;
`endif

endmodule
